// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 16:1 mux channel scanner.
package mux_scan_pkg;

    localparam int unsigned NCH_C  = 16;
    localparam int unsigned SELW_C = 4;
    localparam logic [SELW_C-1:0] LAST_CH_C = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_HOLD
    } state_t;

    // Lowest enabled channel of a mask; 0 when the mask is empty.
    function automatic logic [SELW_C-1:0] first_ch(input logic [NCH_C-1:0] mask);
        logic [SELW_C-1:0] ch;
        logic [SELW_C-1:0] idx;
        ch = '0;
        for (int unsigned i = NCH_C; i > 0; i--) begin
            idx = SELW_C'(i - 1);
            if (mask[idx]) begin
                ch = idx;
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Next enabled channel above the current select, plus a flag when none remains.
// Only built when MUX_SCAN_MASK_EN is defined.
`ifdef MUX_SCAN_MASK_EN
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NCH_C-1:0]  mask,
    input  logic [SELW_C-1:0] cur,
    output logic [SELW_C-1:0] next_ch,
    output logic              last
);

    logic [SELW_C-1:0] idx;

    // Descending walk so the lowest qualifying channel wins.
    always_comb begin
        next_ch = cur;
        last    = 1'b1;
        idx     = '0;
        for (int unsigned i = NCH_C; i > 0; i--) begin
            idx = SELW_C'(i - 1);
            if ((idx > cur) && mask[idx]) begin
                next_ch = idx;
                last    = 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/mux_scan_seq.sv
// Channel scanner: walks the 16:1 mux select, captures mux_y per channel, emits a frame.
// Optional channel masking is enabled by defining MUX_SCAN_MASK_EN.
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int unsigned NCH    = 16,
    parameter int unsigned SELW   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cont,
    input  logic [NCH-1:0]  ch_mask,
    output logic [SELW-1:0] sel,
    input  logic            mux_y,
    output logic [NCH-1:0]  data,
    output logic            data_valid,
    input  logic            data_ready,
    output logic            busy
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t              state_q, state_n;
    logic [SELW_C-1:0]   sel_q, sel_n;
    logic [3:0]          cnt_q, cnt_n;
    logic [NCH_C-1:0]    shadow_q, shadow_n;
    logic [NCH_C-1:0]    data_q, data_n;
    logic                valid_q, valid_n;
    logic                load;

    logic [SELW_C-1:0]   next_ch;
    logic                last;
    logic [SELW_C-1:0]   first_in;
    logic                mask_ok;

`ifdef MUX_SCAN_MASK_EN
    logic [NCH_C-1:0]    mask_q;

    // Mask is captured on the same edge that launches a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (load) begin
            mask_q <= ch_mask;
        end
    end

    assign first_in = first_ch(ch_mask);
    assign mask_ok  = |ch_mask;

    mux_scan_next_ch u_next_ch (
        .mask    (mask_q),
        .cur     (sel_q),
        .next_ch (next_ch),
        .last    (last)
    );
`else
    logic unused_mask;

    assign unused_mask = ^{ch_mask, load};
    assign first_in    = '0;
    assign mask_ok     = 1'b1;
    assign next_ch     = sel_q + 4'd1;
    assign last        = (sel_q == LAST_CH_C);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            sel_q    <= sel_n;
            cnt_q    <= cnt_n;
            shadow_q <= shadow_n;
            data_q   <= data_n;
            valid_q  <= valid_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        sel_n    = sel_q;
        cnt_n    = cnt_q;
        shadow_n = shadow_q;
        data_n   = data_q;
        valid_n  = valid_q;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && mask_ok) begin
                    state_n  = ST_SCAN;
                    sel_n    = first_in;
                    cnt_n    = SETTLE_C;
                    shadow_n = '0;
                    load     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 4'd1;
                end else begin
                    shadow_n[sel_q] = mux_y;
                    if (last) begin
                        // Final bit goes straight into data alongside the shadow bits.
                        data_n  = shadow_n;
                        valid_n = 1'b1;
                        state_n = ST_HOLD;
                    end else begin
                        sel_n = next_ch;
                        cnt_n = SETTLE_C;
                    end
                end
            end
            ST_HOLD: begin
                if (valid_q && data_ready) begin
                    valid_n = 1'b0;
                    if (cont && mask_ok) begin
                        state_n  = ST_SCAN;
                        sel_n    = first_in;
                        cnt_n    = SETTLE_C;
                        shadow_n = '0;
                        load     = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign sel        = sel_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench for mux_scan_seq: dut0 uses SETTLE=1, dut1 uses SETTLE=0.
module tb_mux_scan_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] mask;

    logic        start0, cont0, ready0, y0, valid0, busy0;
    logic [15:0] a0, data0;
    logic [3:0]  sel0;

    logic        start1, cont1, ready1, y1, valid1, busy1;
    logic [15:0] a1, data1;
    logic [3:0]  sel1;

    assign y0 = a0[sel0];
    assign y1 = a1[sel1];

    mux_scan_seq #(.NCH(16), .SELW(4), .SETTLE(1)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start0),
        .cont       (cont0),
        .ch_mask    (mask),
        .sel        (sel0),
        .mux_y      (y0),
        .data       (data0),
        .data_valid (valid0),
        .data_ready (ready0),
        .busy       (busy0)
    );

    mux_scan_seq #(.NCH(16), .SELW(4), .SETTLE(0)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .cont       (cont1),
        .ch_mask    (mask),
        .sel        (sel1),
        .mux_y      (y1),
        .data       (data1),
        .data_valid (valid1),
        .data_ready (ready1),
        .busy       (busy1)
    );

    typedef struct {
        logic [15:0] data;
        int          rise;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad   = 0;
    bit   pv0, pv1;
    int   r0, r1;
    exp_t e;
    int   t0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Call at a negedge; returns at the negedge after the accept edge E0.
    task automatic go0(input logic [15:0] a, input logic [15:0] exp, input int lat,
                       input bit push, output int te0);
        a0     = a;
        start0 = 1'b1;
        te0    = cyc + 1;
        if (push) q0.push_back('{exp, te0 + lat});
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_idle0(input int budget);
        int n;
        n = 0;
        while ((busy0 || valid0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy0 || valid0) begin
            bad++;
            $display("FAIL idle0_timeout: busy=%b valid=%b want 0 0", busy0, valid0);
        end
    endtask

    task automatic wait_valid0(input int budget);
        int n;
        n = 0;
        while (!valid0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!valid0) begin
            bad++;
            $display("FAIL valid0_timeout: valid=%b want 1", valid0);
        end
    endtask

    initial begin
        rst = 1'b1; mask = '0;
        start0 = 1'b0; cont0 = 1'b0; ready0 = 1'b1; a0 = '0;
        start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b1; a1 = '0;
        pv0 = 1'b0; pv1 = 1'b0; r0 = 0; r1 = 0; t0 = 0;
        fork
            // Monitor: one tick after negedge, inputs for the coming edge are settled.
            begin
                forever begin
                    @(negedge clk);
                    #1;
                    if (valid0 && !pv0) r0 = cyc;
                    pv0 = valid0;
                    if (valid0 && ready0) begin
                        if (q0.size() == 0) begin
                            total++; bad++;
                            $display("FAIL frame0_unexpected: got data %h want no frame", data0);
                        end else begin
                            e = q0.pop_front();
                            chk("frame0_data", data0, e.data);
                            chk("frame0_rise", r0, e.rise);
                        end
                    end
                    if (valid1 && !pv1) r1 = cyc;
                    pv1 = valid1;
                    if (valid1 && ready1) begin
                        if (q1.size() == 0) begin
                            total++; bad++;
                            $display("FAIL frame1_unexpected: got data %h want no frame", data1);
                        end else begin
                            e = q1.pop_front();
                            chk("frame1_data", data1, e.data);
                            chk("frame1_rise", r1, e.rise);
                        end
                    end
                end
            end
            begin
                #100000;
                total++; bad++;
                $display("FAIL watchdog: time %0t exceeded", $time);
            end
            begin
                repeat (2) @(negedge clk);
                chk("rst_sel0", sel0, 0);   chk("rst_data0", data0, 0);
                chk("rst_valid0", valid0, 0); chk("rst_busy0", busy0, 0);
                chk("rst_sel1", sel1, 0);   chk("rst_busy1", busy1, 0);
                rst = 1'b0;
                @(negedge clk);

                // Single frame, all bits checked, select walk 2 cycles per channel.
                go0(16'hA5C3, 16'hA5C3, 32, 1'b1, t0);
                for (int k = 0; k < 32; k++) begin
                    chk("t1_sel", sel0, k / 2);
                    chk("t1_busy", busy0, 1);
                    chk("t1_valid_low", valid0, 0);
                    @(negedge clk);
                end
                chk("t1_valid", valid0, 1);
                chk("t1_data", data0, 16'hA5C3);
                @(negedge clk);
                chk("t1_idle", busy0, 0);
                chk("t1_valid_clr", valid0, 0);

                // Backpressure: frame held stable until ready.
                ready0 = 1'b0;
                go0(16'h5A3C, 16'h5A3C, 32, 1'b1, t0);
                wait_valid0(40);
                for (int k = 0; k < 10; k++) begin
                    chk("t2_valid", valid0, 1);
                    chk("t2_data", data0, 16'h5A3C);
                    chk("t2_sel", sel0, 15);
                    chk("t2_busy", busy0, 1);
                    @(negedge clk);
                end
                ready0 = 1'b1;
                @(negedge clk);
                chk("t2_valid_clr", valid0, 0);
                chk("t2_idle", busy0, 0);

                // Continuous mode: back-to-back frames, no idle gap.
                cont0 = 1'b1;
                go0(16'h0001, 16'h0001, 32, 1'b1, t0);
                q0.push_back('{16'h8000, t0 + 33 + 32});
                repeat (32) @(negedge clk);
                chk("t3_valid", valid0, 1);
                a0 = 16'h8000;
                @(negedge clk);
                chk("t3_restart_sel", sel0, 0);
                chk("t3_restart_valid", valid0, 0);
                chk("t3_restart_busy", busy0, 1);
                cont0 = 1'b0;
                wait_idle0(80);

                // Starts while busy (mid-scan and in HOLD with ready) are ignored.
                go0(16'hC3A5, 16'hC3A5, 32, 1'b1, t0);
                for (int k = 0; k < 35; k++) begin
                    start0 = (k == 5 || k == 20 || k == 32);
                    if (k == 32) chk("t4_valid", valid0, 1);
                    if (k == 33 || k == 34) chk("t4_no_restart", busy0, 0);
                    @(negedge clk);
                end
                start0 = 1'b0;

                // Reset mid-frame discards the partial frame.
                go0(16'hFFFF, 16'h0000, 32, 1'b0, t0);
                repeat (10) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("t4_rst_sel", sel0, 0);
                chk("t4_rst_busy", busy0, 0);
                chk("t4_rst_valid", valid0, 0);
                chk("t4_rst_data", data0, 0);
                go0(16'h1234, 16'h1234, 32, 1'b1, t0);
                wait_idle0(40);

`ifdef MUX_SCAN_MASK_EN
                mask = 16'h00F0;
                go0(16'hFFFF, 16'h00F0, 8, 1'b1, t0);
                for (int k = 0; k < 8; k++) begin
                    chk("t5_sel", sel0, 4 + k / 2);
                    @(negedge clk);
                end
                chk("t5_valid", valid0, 1);
                wait_idle0(10);
                mask = 16'h0000;
                start0 = 1'b1;
                @(negedge clk);
                start0 = 1'b0;
                repeat (3) begin
                    chk("t5_zero_busy", busy0, 0);
                    chk("t5_zero_valid", valid0, 0);
                    @(negedge clk);
                end
`else
                mask = 16'h00F0;
                go0(16'hFFFF, 16'hFFFF, 32, 1'b1, t0);
                chk("t5_nomask_sel", sel0, 0);
                wait_idle0(40);
`endif

                // SETTLE=0 instance: select advances every cycle.
                a1 = 16'h3C5A;
                start1 = 1'b1;
                q1.push_back('{16'h3C5A, cyc + 1 + 16});
                @(negedge clk);
                start1 = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    chk("t6_sel", sel1, k);
                    @(negedge clk);
                end
                chk("t6_valid", valid1, 1);
                repeat (3) @(negedge clk);
                chk("t6_idle", busy1, 0);

                repeat (3) @(negedge clk);
                chk("q0_pending", q0.size(), 0);
                chk("q1_pending", q1.size(), 0);
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
